thread_scheduler: RTL

- Round-robin thread-slot generator for the 16-way barrel RISC-V core. It produces the fetch-side thread index that addresses the per-thread PC store, and a matching execute-side index/valid that arrives exactly EXE_STAGE cycles later.
- Owns post-reset PC-store initialisation: walks every thread address once with a write strobe so each thread's PC is loaded with STARTUP_ADDR before issue begins.
- Sits directly upstream of the PC register vector and alongside the pipeline control.

---
 rtl/thread_scheduler.sv | 75 +++++++
 1 files changed

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin fetch slot generator with execute-aligned index/valid and post-reset PC-store init walk
module thread_scheduler #(
  parameter int NUM_THREADS = 16,
  parameter int EXE_STAGE = 7,
  parameter int DWIDTH = 32,
  parameter logic [DWIDTH-1:0] STARTUP_ADDR = '0,
  localparam int TW = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] i_thread_enable,
  output logic [TW-1:0]          o_thread_index_fetch,
  output logic                   o_issue_valid,
  output logic [TW-1:0]          o_thread_index_execute,
  output logic                   o_valid_execute,
  output logic                   o_init_we,
  output logic [TW-1:0]          o_init_addr,
  output logic [DWIDTH-1:0]      o_init_data,
  output logic                   o_round_start,
  output logic                   o_busy_init
);
  typedef enum logic {INIT, RUN} state_t;
  if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0 || EXE_STAGE < 1 || EXE_STAGE >= NUM_THREADS) begin : g_bad_params
    $error("thread_scheduler: need NUM_THREADS power of two >= 2 and 1 <= EXE_STAGE < NUM_THREADS");
  end
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d, fetch_q, fetch_d;
  logic init_we_q, init_we_d;
  logic [EXE_STAGE-1:0][TW-1:0] exe_idx_q, exe_idx_d;
  logic [EXE_STAGE-1:0] exe_vld_q, exe_vld_d;
  logic run, issue_valid, last_init;
  assign run = state_q == RUN;
  assign issue_valid = run & i_thread_enable[fetch_q];
  assign last_init = init_we_q && cnt_q == TW'(NUM_THREADS - 1);
  // next-state: init walk arms one cycle after reset, then free-running fetch index
  always_comb begin
    state_d = last_init ? RUN : state_q;
    init_we_d = !run && !last_init;
    cnt_d = run || last_init ? '0 : cnt_q + TW'(init_we_q);
    fetch_d = run ? fetch_q + TW'(1) : '0;
    exe_idx_d[0] = fetch_q;
    exe_vld_d[0] = issue_valid;
    for (int i = 1; i < EXE_STAGE; i++) begin
      exe_idx_d[i] = exe_idx_q[i-1];
      exe_vld_d[i] = exe_vld_q[i-1];
    end
  end
  // state, init counter, fetch index and execute delay line
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      fetch_q <= '0;
      init_we_q <= 1'b0;
      exe_idx_q <= '0;
      exe_vld_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fetch_q <= fetch_d;
      init_we_q <= init_we_d;
      exe_idx_q <= exe_idx_d;
      exe_vld_q <= exe_vld_d;
    end
  end
  assign o_thread_index_fetch = fetch_q;
  assign o_issue_valid = issue_valid;
  assign o_thread_index_execute = exe_idx_q[EXE_STAGE-1];
  assign o_valid_execute = exe_vld_q[EXE_STAGE-1];
  assign o_init_we = init_we_q;
  assign o_init_addr = cnt_q;
  assign o_init_data = run ? '0 : STARTUP_ADDR;
  assign o_round_start = run && fetch_q == '0;
  assign o_busy_init = !run;
endmodule
